// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the register-file write path.
package regfile_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NPORTS_DEF = 2;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

  // Port-select width; a single port still gets one bit so buses never collapse to zero width.
  function automatic int unsigned psel_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wr_decoder_pipe_if.sv
// Write-port requests in, decoded per-register enables and collision status out.
interface wr_decoder_pipe_if #(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W_DEF,
  parameter int unsigned NPORTS = regfile_pkg::NPORTS_DEF,
  parameter int unsigned CNT_W  = regfile_pkg::CNT_W_DEF
);

  localparam int unsigned NREGS  = 1 << ADDR_W;
  localparam int unsigned PSEL_W = regfile_pkg::psel_w(NPORTS);

  logic                       stall;
  logic [NPORTS-1:0]          wr_en;
  logic [NPORTS*ADDR_W-1:0]   wr_addr;
  logic [NREGS-1:0]           wen;
  logic [NREGS*PSEL_W-1:0]    wsel;
  logic                       any_wr;
  logic                       collision;
  logic [CNT_W-1:0]           collision_cnt;

  modport master (
    output stall, wr_en, wr_addr,
    input  wen, wsel, any_wr, collision, collision_cnt
  );

  modport slave (
    input  stall, wr_en, wr_addr,
    output wen, wsel, any_wr, collision, collision_cnt
  );

endinterface

// File: rtl/decoder_onehot.sv
// Combinational N-to-2**N one-hot decoder with enable.
module decoder_onehot #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     i_en,
  input  logic [ADDR_W-1:0]        i_addr,
  output logic [(1<<ADDR_W)-1:0]   o_dec_c
);

  localparam int unsigned NOUT = 1 << ADDR_W;

  always_comb begin
    o_dec_c = NOUT'(i_en) << i_addr;
  end

endmodule

// File: rtl/wr_decoder_pipe.sv
// Registered multi-port write-enable decoder with fixed-priority port select and
// a saturating same-register collision counter.
module wr_decoder_pipe
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NPORTS   = NPORTS_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  wr_decoder_pipe_if.slave  bus
);

  localparam int unsigned NREGS  = 1 << ADDR_W;
  localparam int unsigned PSEL_W = psel_w(NPORTS);
  localparam int unsigned HIT_W  = $clog2(NPORTS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NPORTS-1:0]              w_live;
  logic [NPORTS-1:0][NREGS-1:0]   w_dec;

  // Per-port decode; a dropped zero-register write simply never enables its decoder.
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [ADDR_W-1:0] w_addr;

    assign w_addr    = bus.wr_addr[p*ADDR_W +: ADDR_W];
    assign w_live[p] = bus.wr_en[p] && !((ZERO_REG != 0) && (w_addr == '0));

    decoder_onehot #(
      .ADDR_W (ADDR_W)
    ) u_dec (
      .i_en    (w_live[p]),
      .i_addr  (w_addr),
      .o_dec_c (w_dec[p])
    );
  end

  logic [NREGS-1:0]              w_wen_nxt;
  logic [NREGS*PSEL_W-1:0]       w_wsel_nxt;
  logic [NREGS-1:0][HIT_W-1:0]   w_hits;
  logic                          w_coll_nxt;

  // Ascending port scan per register: the last (highest-index) live port wins.
  always_comb begin
    w_wen_nxt  = '0;
    w_wsel_nxt = '0;
    w_hits     = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      for (int unsigned q = 0; q < NPORTS; q++) begin
        if (w_dec[q][r]) begin
          w_wen_nxt[r]                  = 1'b1;
          w_wsel_nxt[r*PSEL_W +: PSEL_W] = PSEL_W'(q);
          w_hits[r]                     = w_hits[r] + HIT_W'(1);
        end
      end
    end
  end

  // With a single port the hit count never exceeds one, so this reduces to constant 0.
  always_comb begin
    w_coll_nxt = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (w_hits[r] > HIT_W'(1)) begin
        w_coll_nxt = 1'b1;
      end
    end
  end

  logic [NREGS-1:0]          r_wen;
  logic [NREGS*PSEL_W-1:0]   r_wsel;
  logic                      r_any_wr;
  logic                      r_collision;
  logic [CNT_W-1:0]          r_collision_cnt;

  // Reset wins over stall; a stalled cycle neither captures inputs nor counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wen           <= '0;
      r_wsel          <= '0;
      r_any_wr        <= 1'b0;
      r_collision     <= 1'b0;
      r_collision_cnt <= '0;
    end else if (!bus.stall) begin
      r_wen       <= w_wen_nxt;
      r_wsel      <= w_wsel_nxt;
      r_any_wr    <= |w_wen_nxt;
      r_collision <= w_coll_nxt;
      if (w_coll_nxt && (r_collision_cnt != CNT_MAX)) begin
        r_collision_cnt <= r_collision_cnt + CNT_W'(1);
      end
    end
  end

  // At most one register per live port can be enabled.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.stall) begin
      assert ($countones(w_wen_nxt) <= int'(NPORTS));
    end
  end

  assign bus.wen           = r_wen;
  assign bus.wsel          = r_wsel;
  assign bus.any_wr        = r_any_wr;
  assign bus.collision     = r_collision;
  assign bus.collision_cnt = r_collision_cnt;

endmodule
